// File: rtl/accel_servo_ctrl.sv
// Two-axis servo controller driven by an accelerometer.
// Accumulates N samples per axis, averages and clamps them, maps the result to
// 0..179 degrees, and drives two frame-synchronous servo PWM outputs.
//
// state | meaning
// ------+--------------------------------------------------------------
// ACC   | accept strobes into the per-axis sums until N have been taken
// AVG   | arithmetic-shift average, clamp to [-256,+255], clear sums
// MAP   | scale clamped average to an angle 0..179
// LOAD  | publish angles, pulse angle_valid, write shadow pulse widths
//
// hold stalls the whole sequencer, so a result in flight is published only
// after hold drops; the PWM frame keeps running regardless.
module accel_servo_ctrl #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int PWM_FREQ  = 50,
   parameter int AVG_LOG2  = 3,
   parameter int MIN_PULSE = 50_000,
   parameter int STEP_CLKS = 277
) (
   input  logic       MAX10_CLK1_50,
   input  logic       rst,
   input  logic       sample_valid,
   input  logic [9:0] x_in,
   input  logic [9:0] y_in,
   input  logic       hold,
   output logic [7:0] angle_x,
   output logic [7:0] angle_y,
   output logic       angle_valid,
   output logic       pwm_x,
   output logic       pwm_y
);

   localparam int SUM_W = 10 + AVG_LOG2;
   localparam logic [19:0] PERIOD_M1 = 20'(CLK_FREQ / PWM_FREQ - 1);
   localparam logic [19:0] WIDTH_RST = 20'(MIN_PULSE + 90 * STEP_CLKS);
   localparam logic signed [SUM_W-1:0] AVG_MAX = SUM_W'(255);
   localparam logic signed [SUM_W-1:0] AVG_MIN = SUM_W'(-256);

   typedef enum logic [1:0] {ACC = 2'd0, AVG = 2'd1, MAP = 2'd2, LOAD = 2'd3} state_t;

   state_t                    state_q, state_d;
   logic                      acc_en, avg_en, map_en, load_en;
   logic [AVG_LOG2-1:0]       cnt_q;
   logic signed [SUM_W-1:0]   sum_x_q, sum_y_q;
   logic signed [SUM_W-1:0]   x_ext, y_ext;
   logic signed [8:0]         avg_x_q, avg_y_q;
   logic [7:0]                ang_x_q, ang_y_q;
   logic [7:0]                angle_x_q, angle_y_q;
   logic                      angle_valid_q;
   logic [19:0]               shadow_x_q, shadow_y_q;
   logic [19:0]               active_x_q, active_y_q;
   logic [19:0]               frame_q;
   logic                      pwm_x_q, pwm_y_q;

   assign x_ext = {{AVG_LOG2{x_in[9]}}, x_in};
   assign y_ext = {{AVG_LOG2{y_in[9]}}, y_in};

   function automatic logic signed [8:0] clamp_avg(input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W-1:0] a;
      a = s >>> AVG_LOG2;
      if (a > AVG_MAX)      return 9'h0FF;
      else if (a < AVG_MIN) return 9'h100;
      else                  return a[8:0];
   endfunction

   // avg + 256 over [-256,255] is just the 9-bit value with its sign bit flipped
   function automatic logic [7:0] map_angle(input logic signed [8:0] a);
      logic [16:0] prod;
      prod = 17'({~a[8], a[7:0]}) * 17'd180;
      return 8'(prod >> 9);
   endfunction

   function automatic logic [19:0] pulse_width(input logic [7:0] ang);
      return 20'(MIN_PULSE) + 20'(ang) * 20'(STEP_CLKS);
   endfunction

   // state register
   always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
      if (!rst) state_q <= ACC;
      else      state_q <= state_d;
   end

   // next-state logic; the Nth accepted strobe moves straight on to AVG
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACC:  if (sample_valid && !hold && (cnt_q == '1)) state_d = AVG;
         AVG:  if (!hold) state_d = MAP;
         MAP:  if (!hold) state_d = LOAD;
         LOAD: if (!hold) state_d = ACC;
         default: state_d = ACC;
      endcase
   end

   // per-state datapath enables
   always_comb begin
      acc_en  = 1'b0;
      avg_en  = 1'b0;
      map_en  = 1'b0;
      load_en = 1'b0;
      unique case (state_q)
         ACC:  acc_en  = sample_valid && !hold;
         AVG:  avg_en  = !hold;
         MAP:  map_en  = !hold;
         LOAD: load_en = !hold;
         default: ;
      endcase
   end

   // accumulate, average, map and publish
   always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
      if (!rst) begin
         cnt_q         <= '0;
         sum_x_q       <= '0;
         sum_y_q       <= '0;
         avg_x_q       <= '0;
         avg_y_q       <= '0;
         ang_x_q       <= 8'd90;
         ang_y_q       <= 8'd90;
         angle_x_q     <= 8'd90;
         angle_y_q     <= 8'd90;
         angle_valid_q <= 1'b0;
         shadow_x_q    <= WIDTH_RST;
         shadow_y_q    <= WIDTH_RST;
      end else begin
         angle_valid_q <= 1'b0;
         if (acc_en) begin
            sum_x_q <= sum_x_q + x_ext;
            sum_y_q <= sum_y_q + y_ext;
            cnt_q   <= cnt_q + 1'b1;
         end
         if (avg_en) begin
            avg_x_q <= clamp_avg(sum_x_q);
            avg_y_q <= clamp_avg(sum_y_q);
            sum_x_q <= '0;
            sum_y_q <= '0;
         end
         if (map_en) begin
            ang_x_q <= map_angle(avg_x_q);
            ang_y_q <= map_angle(avg_y_q);
         end
         if (load_en) begin
            angle_x_q     <= ang_x_q;
            angle_y_q     <= ang_y_q;
            angle_valid_q <= 1'b1;
            shadow_x_q    <= pulse_width(ang_x_q);
            shadow_y_q    <= pulse_width(ang_y_q);
         end
      end
   end

   // frame counter; active widths latch from the shadow only at the wrap
   always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
      if (!rst) begin
         frame_q    <= '0;
         active_x_q <= WIDTH_RST;
         active_y_q <= WIDTH_RST;
         pwm_x_q    <= 1'b0;
         pwm_y_q    <= 1'b0;
      end else begin
         if (frame_q == PERIOD_M1) begin
            frame_q    <= '0;
            active_x_q <= shadow_x_q;
            active_y_q <= shadow_y_q;
         end else begin
            frame_q <= frame_q + 20'd1;
         end
         pwm_x_q <= (frame_q < active_x_q);
         pwm_y_q <= (frame_q < active_y_q);
      end
   end

   assign angle_x     = angle_x_q;
   assign angle_y     = angle_y_q;
   assign angle_valid = angle_valid_q;
   assign pwm_x       = pwm_x_q;
   assign pwm_y       = pwm_y_q;

endmodule

// File: tb/tb_accel_servo_ctrl.sv
// Bench for accel_servo_ctrl with a shortened frame (2000 clocks) and small
// pulse constants so several frames fit in a short run.
module tb_accel_servo_ctrl;

   localparam int CLK_FREQ  = 100_000;
   localparam int PWM_FREQ  = 50;
   localparam int PERIOD    = 2000;
   localparam int MIN_PULSE = 200;
   localparam int STEP_CLKS = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sample_valid = 1'b0;
   logic       hold = 1'b0;
   logic [9:0] x_in = '0;
   logic [9:0] y_in = '0;
   logic [7:0] angle_x, angle_y;
   logic       angle_valid, pwm_x, pwm_y;

   accel_servo_ctrl #(
      .CLK_FREQ (CLK_FREQ),
      .PWM_FREQ (PWM_FREQ),
      .AVG_LOG2 (3),
      .MIN_PULSE(MIN_PULSE),
      .STEP_CLKS(STEP_CLKS)
   ) dut (
      .MAX10_CLK1_50(clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .x_in         (x_in),
      .y_in         (y_in),
      .hold         (hold),
      .angle_x      (angle_x),
      .angle_y      (angle_y),
      .angle_valid  (angle_valid),
      .pwm_x        (pwm_x),
      .pwm_y        (pwm_y)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int ax;
      int ay;
      int at;
   } exp_t;
   exp_t sb_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   // expected angle for an 8-sample sum
   function automatic int exp_angle(input int sum);
      int avg;
      avg = sum >>> 3;
      if (avg > 255)  avg = 255;
      if (avg < -256) avg = -256;
      return ((avg + 256) * 180) >> 9;
   endfunction

   function automatic int width_of(input int ang);
      return MIN_PULSE + ang * STEP_CLKS;
   endfunction

   // scoreboard consumer: one entry per angle_valid pulse, checked for value and cycle
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1 && angle_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_angle_valid", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            check("angle_x", 32'(angle_x), 32'(e.ax));
            check("angle_y", 32'(angle_y), 32'(e.ay));
            check("latency_cycle", 32'(cyc), 32'(e.at));
         end
      end
   end

   // pulse width and period observer
   int   run_x = 0, run_y = 0, last_w_x = 0, last_w_y = 0;
   int   pulses_x = 0, pulses_y = 0, rises_x = 0, rise_cyc = 0, last_per_x = 0;
   logic prev_x = 1'b0;
   bit   rise_seen = 1'b0;
   always @(negedge clk) begin
      if (pwm_x === 1'b1) run_x++;
      else if (run_x != 0) begin last_w_x = run_x; run_x = 0; pulses_x++; end
      if (pwm_y === 1'b1) run_y++;
      else if (run_y != 0) begin last_w_y = run_y; run_y = 0; pulses_y++; end
      if (pwm_x === 1'b1 && !prev_x) begin
         rises_x++;
         if (rise_seen) last_per_x = cyc - rise_cyc;
         rise_cyc  = cyc;
         rise_seen = 1'b1;
      end
      prev_x = (pwm_x === 1'b1);
   end

   // bench-side accumulation model
   int m_sx = 0, m_sy = 0, m_n = 0;

   task automatic strobe(input int x, input int y, input bit acc);
      exp_t e;
      @(negedge clk);
      sample_valid = 1'b1;
      x_in = 10'(x);
      y_in = 10'(y);
      @(posedge clk);
      #1;
      if (acc) begin
         m_sx += x;
         m_sy += y;
         m_n++;
         if (m_n == 8) begin
            e.ax = exp_angle(m_sx);
            e.ay = exp_angle(m_sy);
            e.at = cyc + 3;
            sb_q.push_back(e);
            m_sx = 0; m_sy = 0; m_n = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      sample_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int i;
      sample_valid = 1'b0;
      i = 0;
      while (sb_q.size() != 0 && i < 20) begin
         @(posedge clk);
         i++;
      end
      #1;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic wait_pulses();
      int px, py, i;
      px = pulses_x; py = pulses_y; i = 0;
      while ((pulses_x == px || pulses_y == py) && i < 3 * PERIOD) begin
         @(posedge clk);
         i++;
      end
      #1;
      check("pulse_wait_in_time", 32'(i < 3 * PERIOD), 32'd1);
   endtask

   task automatic wait_rise();
      int r, i;
      r = rises_x; i = 0;
      while (rises_x == r && i < 3 * PERIOD) begin
         @(posedge clk);
         i++;
      end
      #1;
      check("rise_wait_in_time", 32'(i < 3 * PERIOD), 32'd1);
   endtask

   initial begin
      // reset values
      repeat (3) @(negedge clk);
      check("rst_angle_x", 32'(angle_x), 32'd90);
      check("rst_angle_y", 32'(angle_y), 32'd90);
      check("rst_angle_valid", 32'(angle_valid), 32'd0);
      check("rst_pwm_x", 32'(pwm_x), 32'd0);
      check("rst_pwm_y", 32'(pwm_y), 32'd0);
      rst = 1'b1;

      // idle frames: 90 degrees on both axes
      wait_pulses();
      wait_pulses();
      check("idle_width_x", 32'(last_w_x), 32'(width_of(90)));
      check("idle_width_y", 32'(last_w_y), 32'(width_of(90)));
      check("frame_period", 32'(last_per_x), 32'(PERIOD));

      // full-scale extremes
      for (int i = 0; i < 8; i++) strobe(255, -256, 1'b1);
      drain();
      check("ext_angle_x", 32'(angle_x), 32'd179);
      check("ext_angle_y", 32'(angle_y), 32'd0);
      wait_pulses();
      check("ext_width_x", 32'(last_w_x), 32'(width_of(179)));
      check("ext_width_y", 32'(last_w_y), 32'(width_of(0)));

      // mixed window, then strobes arriving during AVG/MAP/LOAD are dropped
      for (int i = 0; i < 4; i++) strobe(100, 0, 1'b1);
      for (int i = 0; i < 4; i++) strobe(0, 0, 1'b1);
      for (int i = 0; i < 3; i++) strobe(-512, -512, 1'b0);
      for (int i = 0; i < 8; i++) strobe(400, -100, 1'b1);
      drain();
      check("clamp_hi_angle_x", 32'(angle_x), 32'd179);

      // negative clamp
      for (int i = 0; i < 8; i++) strobe(-512, 0, 1'b1);
      drain();
      check("clamp_lo_angle_x", 32'(angle_x), 32'd0);

      // hold keeps the partial sum and ignores strobes
      for (int i = 0; i < 5; i++) strobe(20, -20, 1'b1);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) strobe(-300, 300, 1'b0);
      hold = 1'b0;
      for (int i = 0; i < 3; i++) strobe(20, -20, 1'b1);
      drain();

      // update landing mid-frame leaves the current pulse alone
      wait_rise();
      idle(300);
      for (int i = 0; i < 8; i++) strobe(-256, 255, 1'b1);
      drain();
      wait_pulses();
      check("midframe_cur_x", 32'(last_w_x), 32'(width_of(exp_angle(8 * 20))));
      check("midframe_cur_y", 32'(last_w_y), 32'(width_of(exp_angle(-8 * 20))));
      wait_pulses();
      check("midframe_next_x", 32'(last_w_x), 32'(width_of(0)));
      check("midframe_next_y", 32'(last_w_y), 32'(width_of(179)));

      // reset mid-accumulation discards the partial window
      for (int i = 0; i < 5; i++) strobe(255, 255, 1'b0);
      sample_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst2_angle_x", 32'(angle_x), 32'd90);
      check("rst2_angle_y", 32'(angle_y), 32'd90);
      check("rst2_pwm_x", 32'(pwm_x), 32'd0);
      rst = 1'b1;
      m_sx = 0; m_sy = 0; m_n = 0;
      for (int i = 0; i < 7; i++) strobe(-256, -256, 1'b1);
      idle(10);
      check("rst2_no_early_valid", 32'(sb_q.size()), 32'd0);
      strobe(-256, -256, 1'b1);
      drain();
      check("rst2_resume_angle_x", 32'(angle_x), 32'd0);
      wait_pulses();
      check("rst2_first_frame_x", 32'(last_w_x), 32'(width_of(90)));
      wait_pulses();
      check("rst2_next_frame_y", 32'(last_w_y), 32'(width_of(0)));

      idle(5);
      check("final_scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
